// File: rtl/seg7_display_mux.sv
// Four-digit common-anode seven-segment scanner for MM.SS stopwatch digits.
// Optional adjust-mode blinking of the selected digit pair when SEG7_BLINK_EN is defined.
module seg7_display_mux #(
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLINK_TICKS = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] min_10s,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic          w_pre_tc;
  logic [3:0]    w_digit;
  logic [3:0]    w_an;
  logic [3:0]    w_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_pre_tc = (r_pre == PW'(DIGIT_TICKS - 1));

  // Scan prescaler and digit ring
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= 2'd0;
    end else if (w_pre_tc) begin
      r_pre <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          w_blink_tc;

  assign w_blink_tc = (r_bcnt == BW'(BLINK_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!rst || !adj) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_blink_tc) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

  // Live adj gates blanking so leaving adjust mode un-blanks on the very next edge.
  always_comb begin
    w_blank = 4'b0000;
    if (adj && r_phase)
      w_blank = sel ? 4'b0011 : 4'b1100;
  end
`else
  logic w_unused_ctrl;
  assign w_unused_ctrl = adj ^ sel;
  assign w_blank       = 4'b0000;
`endif

  always_comb begin
    w_digit = sec_1s;
    case (r_idx)
      2'd0: w_digit = sec_1s;
      2'd1: w_digit = sec_10s;
      2'd2: w_digit = min_1s;
      2'd3: w_digit = min_10s;
      default: w_digit = sec_1s;
    endcase
    w_an = ~(4'b0001 << r_idx);
  end

  // Output register: driven from the pre-update slot and live digits
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= w_an | w_blank;
      seg <= bcd_to_seg(w_digit);
      dp  <= (r_idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_seg7_display_mux.sv
// Bench for seg7_display_mux with DIGIT_TICKS=4, BLINK_TICKS=8; models blink only if SEG7_BLINK_EN.
module tb_seg7_display_mux;

  localparam int DT = 4;
  localparam int BT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sec_1s, sec_10s, min_1s, min_10s;
  logic       adj, sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_display_mux #(.DIGIT_TICKS(DT), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst),
    .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
    .adj(adj), .sel(sel),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bcd;
    logic [6:0] seg;
  } dec_vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } scan_vec_t;

  dec_vec_t  dec_tbl [16];
  scan_vec_t scan_tbl[4];
  out_t      sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_pre = 0;
  int m_idx = 0;
  int m_cnt = 0;
  bit m_ph  = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    return dec_tbl[d].seg;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Push model expectation, advance one clock, pop and compare against DUT.
  task automatic step(input string name);
    out_t e, g;
    logic [3:0] d;
    if (!rst) begin
      e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      case (m_idx)
        0: d = sec_1s;
        1: d = sec_10s;
        2: d = min_1s;
        default: d = min_10s;
      endcase
      e.an  = ~(4'b0001 << m_idx);
`ifdef SEG7_BLINK_EN
      if (adj && m_ph) e.an = e.an | (sel ? 4'b0011 : 4'b1100);
`endif
      e.seg = ref_seg(d);
      e.dp  = (m_idx != 2);
    end
    sb_q.push_back(e);
    if (!rst) begin
      m_pre = 0; m_idx = 0; m_cnt = 0; m_ph = 0;
    end else begin
      if (m_pre == DT - 1) begin
        m_pre = 0; m_idx = (m_idx + 1) % 4;
      end else m_pre++;
      if (!adj) begin
        m_cnt = 0; m_ph = 0;
      end else if (m_cnt == BT - 1) begin
        m_cnt = 0; m_ph = ~m_ph;
      end else m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    g = sb_q.pop_front();
    check({name, ".an"},  {28'd0, an},  {28'd0, g.an});
    check({name, ".seg"}, {25'd0, seg}, {25'd0, g.seg});
    check({name, ".dp"},  {31'd0, dp},  {31'd0, g.dp});
  endtask

  initial begin
    dec_tbl = '{
      '{4'd0, 7'h40}, '{4'd1, 7'h79}, '{4'd2, 7'h24}, '{4'd3, 7'h30},
      '{4'd4, 7'h19}, '{4'd5, 7'h12}, '{4'd6, 7'h02}, '{4'd7, 7'h78},
      '{4'd8, 7'h00}, '{4'd9, 7'h10}, '{4'd10, 7'h7F}, '{4'd11, 7'h7F},
      '{4'd12, 7'h7F}, '{4'd13, 7'h7F}, '{4'd14, 7'h7F}, '{4'd15, 7'h7F}
    };
    scan_tbl = '{
      '{4'b1110, 7'h19, 1'b1}, '{4'b1101, 7'h30, 1'b1},
      '{4'b1011, 7'h24, 1'b0}, '{4'b0111, 7'h79, 1'b1}
    };

    rst = 1'b0; adj = 1'b0; sel = 1'b0;
    min_10s = 4'd1; min_1s = 4'd2; sec_10s = 4'd3; sec_1s = 4'd4;
    @(negedge clk);

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) step("reset");
    check("reset_an", {28'd0, an}, 32'hF);

    // Release: first edge lights slot 0, then the fixed scan table twice (wrap)
    rst = 1'b1;
    step("first");
    check("first_an", {28'd0, an}, 32'hE);
    for (int i = 1; i < 2 * 4 * DT; i++) begin
      int s;
      s = (i / DT) % 4;
      step("scan_sb");
      check("scan_tbl.an",  {28'd0, an},  {28'd0, scan_tbl[s].an});
      check("scan_tbl.seg", {25'd0, seg}, {25'd0, scan_tbl[s].seg});
      check("scan_tbl.dp",  {31'd0, dp},  {31'd0, scan_tbl[s].dp});
    end

    // Decode sweep on slot 0
    for (int v = 0; v < 16; v++) begin
      int guard;
      guard = 0;
      while (m_idx != 0 && guard < 32) begin
        step("sweep_wait");
        guard++;
      end
      sec_1s = v[3:0];
      step("sweep_sb");
      check("sweep.an",  {28'd0, an},  32'hE);
      check("sweep.seg", {25'd0, seg}, {25'd0, dec_tbl[v].seg});
    end
    sec_1s = 4'd5; sec_10s = 4'd9; min_1s = 4'd0; min_10s = 4'd7;
    for (int i = 0; i < 8; i++) step("live_inputs");

    // Adjust mode: seconds pair, minutes pair, then exit (blanks only with SEG7_BLINK_EN)
    adj = 1'b1; sel = 1'b1;
    for (int i = 0; i < 40; i++) step("adj_sec");
    sel = 1'b0;
    for (int i = 0; i < 24; i++) step("adj_min");
    sel = 1'b1;
    for (int i = 0; i < 5; i++) step("adj_sel_flip");
    adj = 1'b0;
    for (int i = 0; i < 12; i++) step("adj_off");
    for (int i = 0; i < 24; i++) begin
      adj = i[2];
      step("adj_toggle");
    end
    adj = 1'b0;

    // Reset while slot 2 is active
    begin
      int guard;
      guard = 0;
      while (m_idx != 2 && guard < 32) begin
        step("pre_rst");
        guard++;
      end
      check("reached_idx2", m_idx, 2);
    end
    step("idx2_entry");
    rst = 1'b0;
    step("mid_rst");
    check("mid_rst_an", {28'd0, an}, 32'hF);
    check("mid_rst_seg", {25'd0, seg}, 32'h7F);
    rst = 1'b1;
    step("post_rst");
    check("post_rst_an", {28'd0, an}, 32'hE);
    for (int i = 0; i < 20; i++) step("post_rst_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
